// File: rtl/decoder3_8_pkg.sv
// Shared constants for the registered 3-to-8 decoder with sticky pending lines.
// Optional overflow tracking in the top level is enabled by DEC_OVERFLOW_EN.
package decoder3_8_pkg;

    localparam int unsigned DEC_CODE_W = 3;
    localparam int unsigned DEC_LINES  = 1 << DEC_CODE_W;

    localparam logic [DEC_LINES-1:0]  DEC_LINE_RST = '0;
    localparam logic [DEC_CODE_W-1:0] DEC_CODE_RST = '0;

endpackage : decoder3_8_pkg

// File: rtl/decoder3_8.sv
// Combinational one-hot decode core with enable: all-zero output when en is low.
module decoder3_8
    import decoder3_8_pkg::*;
#(
    parameter  int unsigned CODE_W = DEC_CODE_W,
    localparam int unsigned LINES  = 1 << CODE_W
) (
    input  logic [CODE_W-1:0] in_code,
    input  logic              en,
    output logic [LINES-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (en && (in_code == CODE_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule : decoder3_8

// File: rtl/decoder3_8_pend.sv
// Registered 3-to-8 decoder with sticky write-1-to-clear pending lines.
// Define DEC_OVERFLOW_EN to add the sticky per-line ovf output.
module decoder3_8_pend
    import decoder3_8_pkg::*;
#(
    parameter  int unsigned CODE_W = DEC_CODE_W,
    localparam int unsigned LINES  = 1 << CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LINES-1:0]  clr,
    output logic [LINES-1:0]  strobe,
    output logic [LINES-1:0]  pending,
    output logic              any_pending,
    output logic [CODE_W-1:0] last_code
`ifdef DEC_OVERFLOW_EN
   ,output logic [LINES-1:0]  ovf
`endif
);

    logic              accept;
    logic [LINES-1:0]  hit;

    logic [LINES-1:0]  strobe_q,    strobe_d;
    logic [LINES-1:0]  pending_q,   pending_d;
    logic              any_q,       any_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;

    assign accept = en & in_valid;

    decoder3_8 #(
        .CODE_W (CODE_W)
    ) u_core (
        .in_code (in_code),
        .en      (accept),
        .onehot  (hit)
    );

    // Set is OR'd after the clear mask so a same-cycle set/clear keeps the event.
    always_comb begin
        strobe_d    = hit;
        pending_d   = (pending_q & ~clr) | hit;
        any_d       = |pending_d;
        last_code_d = last_code_q;
        if (accept) begin
            last_code_d = in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q    <= LINES'(DEC_LINE_RST);
            pending_q   <= LINES'(DEC_LINE_RST);
            any_q       <= 1'b0;
            last_code_q <= CODE_W'(DEC_CODE_RST);
        end else begin
            strobe_q    <= strobe_d;
            pending_q   <= pending_d;
            any_q       <= any_d;
            last_code_q <= last_code_d;
        end
    end

    assign strobe      = strobe_q;
    assign pending     = pending_q;
    assign any_pending = any_q;
    assign last_code   = last_code_q;

`ifdef DEC_OVERFLOW_EN
    logic [LINES-1:0] ovf_q, ovf_d;

    // A repeat only counts as overflow if the line is not being acknowledged now.
    always_comb begin
        ovf_d = (ovf_q & ~clr) | (hit & pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= LINES'(DEC_LINE_RST);
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : decoder3_8_pend
